// File: rtl/iq_window_integrator_if.sv
// Sample stream in / result stream out bundle for iq_window_integrator.
// The bench or upstream DDC drives the master side; the integrator uses the slave side.
interface iq_window_integrator_if #(
  parameter int CH   = 2,
  parameter int IW   = 20,
  parameter int MAXK = 10
);
  localparam int OW  = IW + MAXK;
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic                 i_valid;
  logic [CH*IW-1:0]     i_data_i;
  logic [CH*IW-1:0]     i_data_q;
  logic                 i_ready;
  logic                 o_valid;
  logic [CHW-1:0]       o_ch;
  logic signed [OW-1:0] o_data_i;
  logic signed [OW-1:0] o_data_q;

  modport master (
    output i_valid, i_data_i, i_data_q, i_ready,
    input  o_valid, o_ch, o_data_i, o_data_q
  );

  modport slave (
    input  i_valid, i_data_i, i_data_q, i_ready,
    output o_valid, o_ch, o_data_i, o_data_q
  );
endinterface

// File: rtl/iq_window_integrator.sv
// Multi-channel I/Q window integrator/averager over 2^k samples,
// with a double-buffered result bank drained channel by channel.
module iq_window_integrator #(
  parameter int INT_CHANNELS      = 2,
  parameter int INT_IN_DATA_WIDTH = 20,
  parameter int INT_MAX_AVG_LOG2  = 10,
  localparam int CH  = INT_CHANNELS,
  localparam int IW  = INT_IN_DATA_WIDTH,
  localparam int MK  = INT_MAX_AVG_LOG2,
  localparam int OW  = IW + MK,
  localparam int CW  = $clog2(MK + 1),
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
  localparam int NW  = MK + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  iq_window_integrator_if.slave bus,
  input  logic                  i_avg_cmd_valid,
  input  logic [CW-1:0]         i_avg_cmd_data,
  input  logic                  i_mode_cmd_valid,
  input  logic [1:0]            i_mode_cmd_data,
  input  logic                  i_trig,
  output logic                  o_overrun,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACCUM
  } state_t;

  state_t               state;
  logic [CW-1:0]        k_sh;
  logic [CW-1:0]        k_act;
  logic [1:0]           mode_sh;
  logic                 avg_act;
  logic [NW-1:0]        cnt;
  logic signed [OW-1:0] acc_i  [CH];
  logic signed [OW-1:0] acc_q  [CH];
  logic signed [OW-1:0] bank_i [CH];
  logic signed [OW-1:0] bank_q [CH];
  logic signed [OW-1:0] sum_i  [CH];
  logic signed [OW-1:0] sum_q  [CH];
  logic signed [OW-1:0] res_i  [CH];
  logic signed [OW-1:0] res_q  [CH];
  logic                 full;
  logic [CHW-1:0]       ch;
  logic                 last;
  logic                 hs;
  logic                 hs_last;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum_i[c] = acc_i[c]
        + {{MK{bus.i_data_i[c*IW+IW-1]}}, bus.i_data_i[c*IW +: IW]};
      sum_q[c] = acc_q[c]
        + {{MK{bus.i_data_q[c*IW+IW-1]}}, bus.i_data_q[c*IW +: IW]};
      res_i[c] = avg_act ? (sum_i[c] >>> k_act) : sum_i[c];
      res_q[c] = avg_act ? (sum_q[c] >>> k_act) : sum_q[c];
    end
  end

  assign last    = (cnt == ((NW'(1) << k_act) - NW'(1)));
  assign hs      = full & bus.i_ready;
  assign hs_last = hs && (ch == CHW'(CH - 1));

  assign bus.o_valid  = full;
  assign bus.o_ch     = ch;
  assign bus.o_data_i = bank_i[ch];
  assign bus.o_data_q = bank_q[ch];
  assign o_busy       = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_sh      <= '0;
      k_act     <= '0;
      mode_sh   <= '0;
      avg_act   <= 1'b0;
      cnt       <= '0;
      full      <= 1'b0;
      ch        <= '0;
      o_overrun <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        acc_i[c]  <= '0;
        acc_q[c]  <= '0;
        bank_i[c] <= '0;
        bank_q[c] <= '0;
      end
    end else begin
      if (i_avg_cmd_valid) begin
        k_sh      <= (i_avg_cmd_data > CW'(MK)) ? CW'(MK)
                                                : i_avg_cmd_data;
        o_overrun <= 1'b0;
      end
      if (i_mode_cmd_valid) mode_sh <= i_mode_cmd_data;

      if (hs) begin
        if (hs_last) begin
          full <= 1'b0;
          ch   <= '0;
        end else begin
          ch <= ch + CHW'(1);
        end
      end

      unique case (state)
        IDLE: begin
          k_act   <= k_sh;
          avg_act <= mode_sh[0];
          state   <= mode_sh[1] ? ARMED : ACCUM;
        end
        ARMED: begin
          if (i_trig) state <= ACCUM;
        end
        ACCUM: begin
          if (bus.i_valid) begin
            if (last) begin
              cnt     <= '0;
              k_act   <= k_sh;
              avg_act <= mode_sh[0];
              if (mode_sh[1]) state <= ARMED;
              for (int c = 0; c < CH; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
              end
              // A bank freed by this cycle's final handshake may reload
              if (!full || hs_last) begin
                full <= 1'b1;
                ch   <= '0;
                for (int c = 0; c < CH; c++) begin
                  bank_i[c] <= res_i[c];
                  bank_q[c] <= res_q[c];
                end
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              cnt <= cnt + NW'(1);
              for (int c = 0; c < CH; c++) begin
                acc_i[c] <= sum_i[c];
                acc_q[c] <= sum_q[c];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_window_integrator.sv
// Bench for iq_window_integrator: directed scenarios plus random traffic,
// checked each cycle against a sample-list reference model.
module tb_iq_window_integrator;
  localparam int CH = 2;
  localparam int IW = 20;
  localparam int MK = 10;
  localparam int OW = IW + MK;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iq_window_integrator_if #(.CH(CH), .IW(IW), .MAXK(MK)) bus ();

  logic          avg_v  = 1'b0;
  logic [CW-1:0] avg_d  = '0;
  logic          mode_v = 1'b0;
  logic [1:0]    mode_d = '0;
  logic          trig   = 1'b0;
  logic          overrun;
  logic          busy;

  iq_window_integrator #(
    .INT_CHANNELS(CH),
    .INT_IN_DATA_WIDTH(IW),
    .INT_MAX_AVG_LOG2(MK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .i_avg_cmd_valid(avg_v),
    .i_avg_cmd_data(avg_d),
    .i_mode_cmd_valid(mode_v),
    .i_mode_cmd_data(mode_d),
    .i_trig(trig),
    .o_overrun(overrun),
    .o_busy(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit valid = 1'b0;
  bit ready = 1'b1;
  int di [CH];
  int dq [CH];

  // reference model: 0 = idle, 1 = armed, 2 = accumulating
  int       m_state;
  int       sh_k, act_k;
  bit [1:0] sh_mode, act_mode;
  int       qi [CH][$];
  int       qq [CH][$];
  longint   bi [CH];
  longint   bq [CH];
  bit       m_full;
  int       m_ptr;
  bit       m_ovr;
  int       m_bounds = 0;

  task automatic check(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_res(input int s[$], input int k,
                                     input bit avg);
    longint sum, d, r;
    sum = 0;
    foreach (s[j]) sum += s[j];
    if (!avg) return sum;
    d = longint'(1) << k;
    r = sum / d;
    if ((sum % d != 0) && (sum < 0)) r -= 1;
    return r;
  endfunction

  function automatic int rnd_smp();
    return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
  endfunction

  task automatic model_reset();
    m_state = 0;
    sh_k = 0; act_k = 0;
    sh_mode = 0; act_mode = 0;
    m_full = 0; m_ptr = 0; m_ovr = 0;
    for (int c = 0; c < CH; c++) begin
      qi[c].delete(); qq[c].delete();
      bi[c] = 0; bq[c] = 0;
    end
  endtask

  task automatic model_step();
    if (avg_v) m_ovr = 0;
    if (m_full && ready) begin
      if (m_ptr == CH - 1) begin
        m_full = 0;
        m_ptr = 0;
      end else begin
        m_ptr++;
      end
    end
    case (m_state)
      0: begin
        act_k = sh_k; act_mode = sh_mode;
        m_state = sh_mode[1] ? 1 : 2;
        m_bounds++;
      end
      1: if (trig) m_state = 2;
      default: if (valid) begin
        for (int c = 0; c < CH; c++) begin
          qi[c].push_back(di[c]);
          qq[c].push_back(dq[c]);
        end
        if (qi[0].size() == (1 << act_k)) begin
          if (!m_full) begin
            for (int c = 0; c < CH; c++) begin
              bi[c] = ref_res(qi[c], act_k, act_mode[0]);
              bq[c] = ref_res(qq[c], act_k, act_mode[0]);
            end
            m_full = 1;
            m_ptr = 0;
          end else begin
            m_ovr = 1;
          end
          for (int c = 0; c < CH; c++) begin
            qi[c].delete(); qq[c].delete();
          end
          act_k = sh_k; act_mode = sh_mode;
          m_state = sh_mode[1] ? 1 : 2;
          m_bounds++;
        end
      end
    endcase
    if (avg_v) sh_k = (avg_d > MK) ? MK : int'(avg_d);
    if (mode_v) sh_mode = mode_d;
  endtask

  task automatic check_outputs();
    check("o_valid", bus.o_valid, m_full);
    check("o_ch", bus.o_ch, m_ptr);
    check("o_busy", busy, m_state == 2);
    check("o_overrun", overrun, m_ovr);
    if (m_full) begin
      check("o_data_i", bus.o_data_i, bi[m_ptr]);
      check("o_data_q", bus.o_data_q, bq[m_ptr]);
    end
  endtask

  task automatic cyc();
    for (int c = 0; c < CH; c++) begin
      bus.i_data_i[c*IW +: IW] = IW'(di[c]);
      bus.i_data_q[c*IW +: IW] = IW'(dq[c]);
    end
    bus.i_valid = valid;
    bus.i_ready = ready;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    avg_v = 0; mode_v = 0; trig = 0;
    check_outputs();
  endtask

  task automatic set_cfg(input int k, input bit [1:0] mode);
    int b0;
    bit ok;
    avg_v = 1; avg_d = CW'(k);
    mode_v = 1; mode_d = mode;
    valid = 0; ready = 1;
    cyc();
    b0 = m_bounds;
    ok = 0;
    for (int n = 0; n < 2200 && !ok; n++) begin
      valid = 1;
      for (int c = 0; c < CH; c++) begin
        di[c] = rnd_smp(); dq[c] = rnd_smp();
      end
      trig = (m_state == 1);
      cyc();
      ok = (m_bounds != b0);
    end
    check("cfg_applied", ok, 1);
    valid = 0;
    repeat (CH + 1) cyc();
  endtask

  task automatic win(input int n, input int first, input int rest);
    valid = 1;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < CH; c++) begin
        di[c] = (j == 0) ? first : rest;
        dq[c] = di[c];
      end
      cyc();
    end
    valid = 0;
  endtask

  task automatic expect_pair(input string tag,
                             input longint i0, input longint q0,
                             input longint i1, input longint q1);
    check({tag, "_v"}, bus.o_valid, 1);
    check({tag, "_ch0"}, bus.o_ch, 0);
    check({tag, "_i0"}, bus.o_data_i, i0);
    check({tag, "_q0"}, bus.o_data_q, q0);
    valid = 0; ready = 1;
    cyc();
    check({tag, "_ch1"}, bus.o_ch, 1);
    check({tag, "_i1"}, bus.o_data_i, i1);
    check({tag, "_q1"}, bus.o_data_q, q1);
    cyc();
    check({tag, "_empty"}, bus.o_valid, 0);
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      di[c] = 0; dq[c] = 0;
    end
    model_reset();

    rst = 1;
    repeat (3) cyc();
    check("rst_valid", bus.o_valid, 0);
    check("rst_ch", bus.o_ch, 0);
    check("rst_data_i", bus.o_data_i, 0);
    check("rst_data_q", bus.o_data_q, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    cyc();

    // continuous integrate, k=2
    set_cfg(2, 2'b00);
    valid = 1;
    for (int n = 0; n < 4; n++) begin
      di[0] = n + 1; dq[0] = -(n + 1);
      di[1] = 100;   dq[1] = 100;
      cyc();
    end
    expect_pair("t1", 10, -10, 400, 400);

    // average vs integrate, k=3
    set_cfg(3, 2'b01);
    win(8, -3, -3);
    expect_pair("t2_avg", -3, -3, -3, -3);
    win(8, -1, 0);
    expect_pair("t2_floor", -1, -1, -1, -1);
    set_cfg(3, 2'b00);
    win(8, -3, -3);
    expect_pair("t2_int", -24, -24, -24, -24);
    win(8, -1, 0);
    expect_pair("t2_int1", -1, -1, -1, -1);

    // triggered, k=2
    set_cfg(2, 2'b10);
    win(6, 11, 11);
    check("t3_notrig_v", bus.o_valid, 0);
    check("t3_notrig_busy", busy, 0);
    valid = 1;
    for (int c = 0; c < CH; c++) begin
      di[c] = 1000; dq[c] = 1000;
    end
    trig = 1;
    cyc();
    check("t3_started", busy, 1);
    win(4, 1, 2);
    check("t3_rearmed", busy, 0);
    expect_pair("t3", 7, 7, 7, 7);
    trig = 1; valid = 0;
    cyc();
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < CH; c++) begin
        di[c] = 5; dq[c] = 5;
      end
      valid = 1;
      trig = (n == 2);
      cyc();
    end
    check("t3_midtrig_busy", busy, 0);
    expect_pair("t3_mid", 20, 20, 20, 20);

    // overrun, then coincident drain/reload
    set_cfg(2, 2'b00);
    ready = 0;
    win(4, 1, 1);
    win(4, 2, 2);
    check("t4_ovr", overrun, 1);
    check("t4_held", bus.o_data_i, 4);
    expect_pair("t4_first", 4, 4, 4, 4);
    avg_v = 1; avg_d = 2; valid = 0;
    cyc();
    check("t4_ovr_clr", overrun, 0);
    win(4, 3, 3);
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < CH; c++) begin
        di[c] = 6; dq[c] = 6;
      end
      valid = 1;
      ready = (n >= 2);
      cyc();
      if (n == 2) begin
        check("t4_a_ch1", bus.o_ch, 1);
        check("t4_a_i1", bus.o_data_i, 12);
      end
    end
    check("t4_no_ovr", overrun, 0);
    expect_pair("t4_b", 24, 24, 24, 24);

    // k change mid-window, then clamp of k=15
    set_cfg(2, 2'b00);
    valid = 1;
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < CH; c++) begin
        di[c] = n + 1; dq[c] = n + 1;
      end
      avg_v = (n == 1);
      avg_d = 1;
      cyc();
    end
    expect_pair("t5_old", 10, 10, 10, 10);
    win(2, 7, 8);
    expect_pair("t5_new", 15, 15, 15, 15);
    set_cfg(15, 2'b00);
    win(1023, -(1 << 19), -(1 << 19));
    check("t6_not_yet", bus.o_valid, 0);
    win(1, -(1 << 19), -(1 << 19));
    expect_pair("t6_max", -(64'sd1 << 29), -(64'sd1 << 29),
                -(64'sd1 << 29), -(64'sd1 << 29));

    // reset while bank full and mid-window
    set_cfg(2, 2'b00);
    ready = 0;
    win(4, 1, 1);
    win(2, 50, 50);
    rst = 1;
    cyc();
    check("t6_rst_v", bus.o_valid, 0);
    check("t6_rst_busy", busy, 0);
    rst = 0; valid = 0; ready = 1;
    cyc();
    win(1, 9, 9);
    expect_pair("t6_after", 9, 9, 9, 9);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      valid = ($urandom_range(0, 9) < 7);
      ready = ($urandom_range(0, 3) != 0);
      trig  = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < CH; c++) begin
        di[c] = rnd_smp(); dq[c] = rnd_smp();
      end
      if ($urandom_range(0, 99) == 0) begin
        avg_v = 1; avg_d = CW'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 99) == 0) begin
        mode_v = 1; mode_d = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc();
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
